fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the SDRAM-side asynchronous FIFO among NREQ requesters in the write clock domain. It grants one requester at a time for a whole burst. Each beat is written tagged with the source ID, so the read side can route returned data. It also throttles on FIFO full and almost-full, so the FIFO never overflows.

---
 rtl/fifo_wr_arbiter.sv | 159 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the write port of the
// SDRAM-side async FIFO among NREQ requesters. A grant covers one whole burst
// of req_len+1 beats. Each beat is tagged with its source ID. New grants are
// held off on fifo_afull, and beats are held off on fifo_full.
// Optional feature macro: FIFOARB_TIMEOUT_EN. When defined, a burst whose
// owner stalls for TMO cycles is aborted.
module fifo_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2,
  parameter int LENW = 4,
  parameter int TMO  = 16
) (
  input  logic                 wr_clk,
  input  logic                 wr_reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*W-1:0]    req_data,
  input  logic [NREQ*LENW-1:0] req_len,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      grant,
  output logic                 fifo_wr_en,
  output logic [IDW+W-1:0]     fifo_wr_data,
  input  logic                 fifo_full,
  input  logic                 fifo_afull,
  output logic                 busy,
  output logic                 abort
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [IDW-1:0]  src_id;
  logic [IDW-1:0]  last;
  logic [LENW-1:0] beat_cnt;

  logic            win_found;
  int unsigned     win_idx;
  logic [LENW-1:0] win_len;

  logic            owner_valid;
  logic [W-1:0]    owner_data;

  // Round-robin search: first valid requester strictly after 'last', wrapping
  always_comb begin
    logic [NREQ-1:0] shifted;
    int unsigned     cand;
    win_found = 1'b0;
    win_idx   = 0;
    win_len   = '0;
    shifted   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand    = (32'(last) + k) % NREQ;
      shifted = req_valid >> cand;
      if (!win_found && shifted[0]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (i == win_idx) win_len = req_len[i*LENW +: LENW];
    end
  end

  // Select the current owner's valid and payload from the one-hot grant
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*W +: W];
      end
    end
  end

  assign busy = (state == BURST);

  // Write-side handshake: fifo_full gates ready and wr_en combinationally
  always_comb begin
    fifo_wr_en   = busy & owner_valid & ~fifo_full;
    req_ready    = (busy && !fifo_full) ? grant : '0;
    fifo_wr_data = busy ? {src_id, owner_data} : '0;
  end

`ifdef FIFOARB_TIMEOUT_EN
  localparam int SW = $clog2(TMO + 1);
  logic [SW-1:0] stall_cnt;
  logic          abort_q;

  assign abort = abort_q;
`else
  // TMO only matters when the stall timeout is built in
  logic unused_tmo;
  assign unused_tmo = |32'(TMO);
  assign abort = 1'b0;
`endif

  // Burst FSM: arbitrates in IDLE and counts accepted beats in BURST
  always_ff @(posedge wr_clk or posedge wr_reset) begin
    if (wr_reset) begin
      state    <= IDLE;
      grant    <= '0;
      src_id   <= '0;
      beat_cnt <= '0;
      last     <= IDW'(NREQ - 1);
`ifdef FIFOARB_TIMEOUT_EN
      stall_cnt <= '0;
      abort_q   <= 1'b0;
`endif
    end else begin
`ifdef FIFOARB_TIMEOUT_EN
      abort_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_found && !fifo_afull) begin
            state    <= BURST;
            grant    <= NREQ'(1) << win_idx;
            src_id   <= IDW'(win_idx);
            beat_cnt <= win_len;
            last     <= IDW'(win_idx);
`ifdef FIFOARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
          end
        end
        BURST: begin
          if (fifo_wr_en) begin
`ifdef FIFOARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (beat_cnt == '0) begin
              state <= IDLE;
              grant <= '0;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end
`ifdef FIFOARB_TIMEOUT_EN
          // Only owner gaps count; full stalls with valid high do not
          else if (!owner_valid) begin
            if (stall_cnt == SW'(TMO - 1)) begin
              state     <= IDLE;
              grant     <= '0;
              stall_cnt <= '0;
              abort_q   <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (NREQ=4, W=8, IDW=2, LENW=4, TMO=16).
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int LENW = 4;
  localparam int TMO  = 16;

  logic                 wr_clk;
  logic                 wr_reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*W-1:0]    req_data;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      grant;
  logic                 fifo_wr_en;
  logic [IDW+W-1:0]     fifo_wr_data;
  logic                 fifo_full;
  logic                 fifo_afull;
  logic                 busy;
  logic                 abort;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .LENW(LENW), .TMO(TMO)) dut (
    .wr_clk       (wr_clk),
    .wr_reset     (wr_reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_len      (req_len),
    .req_ready    (req_ready),
    .grant        (grant),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .fifo_afull   (fifo_afull),
    .busy         (busy),
    .abort        (abort)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [LENW-1:0] len, input logic [W-1:0] data);
    req_len[i*LENW +: LENW] = len;
    req_data[i*W +: W]      = data;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_grant"}, 32'(grant), 0);
    check_eq({tag, "_ready"}, 32'(req_ready), 0);
    check_eq({tag, "_wren"},  32'(fifo_wr_en), 0);
    check_eq({tag, "_wdata"}, 32'(fifo_wr_data), 0);
    check_eq({tag, "_busy"},  32'(busy), 0);
    check_eq({tag, "_abort"}, 32'(abort), 0);
  endtask

  initial begin
    int nb;
    int dut_beats;
    int exp_en;
    int exp_busy;
    int id;
    int idle_cnt;
    int seen;

    req_valid  = '0;
    req_data   = '0;
    req_len    = '0;
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    wr_reset   = 1'b1;

    // Reset values
    repeat (2) @(negedge wr_clk);
    #1 check_idle_outputs("rst");

    // Single requester 2, four beats 0xA0..0xA3
    @(negedge wr_clk);
    wr_reset = 1'b0;
    @(negedge wr_clk);
    req_valid = 4'b0100;
    set_lane(2, 4'd3, 8'hA0);
    #1 check_eq("single_pre_busy", 32'(busy), 0);
    check_eq("single_pre_wren", 32'(fifo_wr_en), 0);
    for (int b = 0; b < 4; b++) begin
      @(negedge wr_clk);
      set_lane(2, 4'd3, 8'(8'hA0 + b));
      #1 check_eq("single_busy", 32'(busy), 1);
      check_eq("single_grant", 32'(grant), 32'h4);
      check_eq("single_ready", 32'(req_ready), 32'h4);
      check_eq("single_wren", 32'(fifo_wr_en), 1);
      check_eq("single_wdata", 32'(fifo_wr_data), 32'h2A0 + b);
    end
    @(negedge wr_clk);
    req_valid = '0;
    #1 check_eq("single_done_busy", 32'(busy), 0);
    check_eq("single_done_grant", 32'(grant), 0);

    // Round robin after a fresh reset: 0,1,2,3,0 with one IDLE cycle between
    @(negedge wr_clk);
    wr_reset = 1'b1;
    #1 check_eq("rr_rst_busy", 32'(busy), 0);
    @(negedge wr_clk);
    wr_reset  = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) set_lane(i, 4'd0, 8'(16 * (i + 1)));
    #1 check_eq("rr_pre_grant", 32'(grant), 0);
    for (int k = 0; k < 9; k++) begin
      @(negedge wr_clk);
      #1;
      if (k % 2 == 0) begin
        id = (k / 2) % 4;
        check_eq("rr_grant", 32'(grant), 32'(1) << id);
        check_eq("rr_wren", 32'(fifo_wr_en), 1);
        check_eq("rr_wdata", 32'(fifo_wr_data), (id << 8) | (16 * (id + 1)));
      end else begin
        check_eq("rr_gap_grant", 32'(grant), 0);
        check_eq("rr_gap_wren", 32'(fifo_wr_en), 0);
      end
    end
    @(negedge wr_clk);
    req_valid = '0;
    #1 check_eq("rr_done_busy", 32'(busy), 0);

    // Back-pressure: requester 1, 8 beats, fifo_full held for three cycles
    nb        = 0;
    dut_beats = 0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge wr_clk);
      fifo_full = (c >= 3 && c <= 5);
      req_valid = (c < 12) ? 4'b0010 : 4'b0000;
      set_lane(1, 4'd7, 8'(8'h50 + nb));
      #1;
      exp_busy = (c >= 1 && c <= 11) ? 1 : 0;
      exp_en   = (exp_busy == 1 && !fifo_full) ? 1 : 0;
      check_eq("bp_busy", 32'(busy), 32'(exp_busy));
      check_eq("bp_wren", 32'(fifo_wr_en), 32'(exp_en));
      check_eq("bp_ready", 32'(req_ready), (exp_en == 1) ? 32'h2 : 32'h0);
      if (fifo_full) check_eq("bp_no_wren_when_full", 32'(fifo_wr_en), 0);
      if (exp_en == 1) begin
        check_eq("bp_wdata", 32'(fifo_wr_data), 32'h150 + nb);
        nb++;
      end
      if (fifo_wr_en) dut_beats++;
    end
    fifo_full = 1'b0;
    check_eq("bp_beat_total", 32'(dut_beats), 8);

    // Almost-full gating, then grant goes to requester 2 (after owner 1)
    @(negedge wr_clk);
    fifo_afull = 1'b1;
    req_valid  = 4'hF;
    for (int i = 0; i < NREQ; i++) set_lane(i, 4'd0, 8'(16 * (i + 1)));
    for (int k = 0; k < 3; k++) begin
      @(negedge wr_clk);
      #1 check_eq("afull_grant", 32'(grant), 0);
    end
    @(negedge wr_clk);
    fifo_afull = 1'b0;
    #1 check_eq("afull_drop_grant", 32'(grant), 0);
    @(negedge wr_clk);
    #1 check_eq("afull_next_grant", 32'(grant), 32'h4);
    check_eq("afull_next_wdata", 32'(fifo_wr_data), 32'h230);
    @(negedge wr_clk);
    req_valid = '0;
    #1 check_eq("afull_done_busy", 32'(busy), 0);

    // Reset mid-burst, then requester 3 with a newly sampled length
    @(negedge wr_clk);
    req_valid = 4'b0001;
    set_lane(0, 4'd5, 8'hC0);
    for (int b = 0; b < 2; b++) begin
      @(negedge wr_clk);
      #1 check_eq("mid_wren", 32'(fifo_wr_en), 1);
    end
    @(negedge wr_clk);
    wr_reset = 1'b1;
    #1 check_idle_outputs("mid_rst");
    @(negedge wr_clk);
    wr_reset  = 1'b0;
    req_valid = 4'b1000;
    set_lane(3, 4'd2, 8'hD0);
    #1 check_eq("mid_rel_busy", 32'(busy), 0);
    for (int b = 0; b < 3; b++) begin
      @(negedge wr_clk);
      set_lane(3, 4'd2, 8'(8'hD0 + b));
      #1 check_eq("mid_grant", 32'(grant), 32'h8);
      check_eq("mid_wren3", 32'(fifo_wr_en), 1);
      check_eq("mid_wdata", 32'(fifo_wr_data), 32'h3D0 + b);
    end
    @(negedge wr_clk);
    req_valid = '0;
    #1 check_eq("mid_done_busy", 32'(busy), 0);

`ifdef FIFOARB_TIMEOUT_EN
    // Owner 0 stalls after one beat; abort after TMO idle cycles, then 1 wins
    @(negedge wr_clk);
    req_valid = 4'b0001;
    set_lane(0, 4'd3, 8'hE0);
    @(negedge wr_clk);
    #1 check_eq("to_beat0", 32'(fifo_wr_en), 1);
    @(negedge wr_clk);
    req_valid = 4'b0010;
    #1 check_eq("to_stall_busy", 32'(busy), 1);
    idle_cnt = 1;
    seen     = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge wr_clk);
      #1;
      if (abort) seen = 1;
      else if (busy && !fifo_wr_en) idle_cnt++;
    end
    check_eq("to_abort_seen", 32'(seen), 1);
    check_eq("to_idle_cycles", 32'(idle_cnt), TMO);
    check_eq("to_abort_busy", 32'(busy), 0);
    check_eq("to_abort_grant", 32'(grant), 0);
    @(negedge wr_clk);
    #1 check_eq("to_abort_width", 32'(abort), 0);
    check_eq("to_next_grant", 32'(grant), 32'h2);
    @(negedge wr_clk);
    req_valid = '0;
`else
    // Without the timeout a gapping owner keeps its grant indefinitely
    @(negedge wr_clk);
    req_valid = 4'b0001;
    set_lane(0, 4'd1, 8'hE0);
    @(negedge wr_clk);
    #1 check_eq("gap_beat0", 32'(fifo_wr_en), 1);
    check_eq("gap_wdata0", 32'(fifo_wr_data), 32'h0E0);
    @(negedge wr_clk);
    req_valid = '0;
    repeat (20) @(negedge wr_clk);
    #1 check_eq("gap_busy", 32'(busy), 1);
    check_eq("gap_grant", 32'(grant), 32'h1);
    check_eq("gap_abort", 32'(abort), 0);
    @(negedge wr_clk);
    req_valid = 4'b0001;
    set_lane(0, 4'd1, 8'hE1);
    #1 check_eq("gap_beat1", 32'(fifo_wr_en), 1);
    check_eq("gap_wdata1", 32'(fifo_wr_data), 32'h0E1);
    @(negedge wr_clk);
    req_valid = '0;
    #1 check_eq("gap_done_busy", 32'(busy), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
